trap_sequencer: RTL and testbench
=================================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have one clock, i_clk; all state updates on its rising edge.
REQ-002 SHALL have i_rst, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have i_exc_valid_m, input, 1: the instruction in MEM raised a synchronous exception.
REQ-004 SHALL have i_exc_cause_m, input, 4: exception code of that instruction.
REQ-005 SHALL have i_tval_m, input, 32: faulting address or instruction word.
REQ-006 SHALL have i_pc_m, input, 32: PC of the instruction in MEM.
REQ-007 SHALL have i_pc_valid_m, input, 1: MEM holds a real, non-bubble instruction.
REQ-008 SHALL have i_irq_ext, input, 1: level-sensitive machine external interrupt.
REQ-009 SHALL have i_mstatus, input, 32: current mstatus; bit 3 = MIE.
REQ-010 SHALL have i_mie_meie, input, 1: mie.MEIE.
REQ-011 SHALL have i_mtvec, input, 32: current mtvec; bits [1:0] = mode.
REQ-012 SHALL have i_mret_e, input, 1: mret is in EX.
REQ-013 SHALL have o_flush_all, output, 1: flush IF/ID, ID/EX and EX/MEM.
REQ-014 SHALL have o_pc_stall, output, 1: hold the PC.
REQ-015 SHALL have o_redirect_valid, output, 1: load o_redirect_pc into the PC.
REQ-016 SHALL have o_redirect_pc, output, 32: trap handler address.
REQ-017 SHALL have o_csr_we, output, 1: CSR write strobe.
REQ-018 SHALL have o_csr_addr, output, 12: CSR write address.
REQ-019 SHALL have o_csr_wdata, output, 32: CSR write data.
REQ-020 SHALL have o_busy, output, 1: a trap sequence is in progress.

Function
REQ-021 SHALL implement a Moore FSM with states IDLE, FLUSH, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS and REDIRECT.
REQ-022 SHALL drive all outputs from the registered state and captured registers only, with no combinational path from any input.
REQ-023 SHALL, in IDLE, take an exception when i_exc_valid_m=1.
REQ-024 SHALL, in IDLE, take an interrupt when i_irq_ext & i_mie_meie & i_mstatus[3] & i_pc_valid_m & !i_mret_e & !i_exc_valid_m.
REQ-025 SHALL give the exception priority when an exception and an interrupt are both pending.
REQ-026 SHALL NOT take an interrupt in a cycle with i_mret_e=1, so mret completes first; an exception is still taken in that cycle.
REQ-027 SHALL, on a trap, capture in the same edge:
- pc_q = i_pc_m
- irq_q = interrupt flag
- cause_q = i_exc_cause_m for an exception, 4'd11 for an interrupt
- tval_q = i_tval_m for an exception, 0 for an interrupt
- mstatus_q = i_mstatus
- mtvec_q = i_mtvec

The FSM then goes to FLUSH.
REQ-028 SHALL advance one state per cycle, unconditionally: FLUSH -> W_MEPC -> W_MCAUSE -> W_MTVAL -> W_MSTATUS -> REDIRECT -> IDLE; the busy period is 6 cycles.
REQ-029 SHALL drive o_busy=1 and o_flush_all=1 in every non-IDLE state.
REQ-030 SHALL drive o_pc_stall=1 in FLUSH through W_MSTATUS and 0 in REDIRECT.
REQ-031 SHALL assert o_csr_we=1 only in the four W_* states, with:
- W_MEPC: address 0x341, data {pc_q[31:2], 2'b00}
- W_MCAUSE: address 0x342, data {irq_q, 27'b0, cause_q}
- W_MTVAL: address 0x343, data tval_q
- W_MSTATUS: address 0x300, data = mstatus_q with MPIE(7) = old MIE(3), MIE(3) = 0, MPP(12:11) = 2'b11, all other bits unchanged
REQ-032 SHALL drive o_csr_addr=0 and o_csr_wdata=0 in every state where o_csr_we=0.
REQ-033 SHALL assert o_redirect_valid=1 only in REDIRECT, with o_redirect_pc computed as:
- base = {mtvec_q[31:2], 2'b00}
- if irq_q=1 and mtvec_q[1:0]=2'b01, the result is base + {26'b0, cause_q, 2'b00}, truncated to 32 bits
- otherwise the result is base
REQ-034 SHALL drive o_redirect_pc=0 outside REDIRECT.
REQ-035 SHALL ignore all trap inputs while o_busy=1; they are neither queued nor counted.
REQ-036 SHALL allow a new trap to be accepted in the IDLE cycle immediately after REDIRECT.

Reset
REQ-037 SHALL, with i_rst=1 at a clock edge, force state=IDLE and clear every captured register to 0.
REQ-038 SHALL hold all outputs at 0 in the cycle after reset.
REQ-039 SHALL apply reset in any state; a sequence in progress is abandoned, and no further CSR write or redirect is issued.

Verification
REQ-040 Exception path: i_exc_valid_m=1, cause=2, pc=0x0000_0104, tval=0xDEAD_BEEF, mtvec=0x0000_0200. Required response:
- CSR writes in order: 0x341 <- 0x104, 0x342 <- 0x2, 0x343 <- 0xDEADBEEF, 0x300 <- updated mstatus
- o_redirect_pc = 0x200 on cycle 6
REQ-041 Vectored interrupt: irq=1, MEIE=1, MIE=1, mtvec=0x0000_0201. Required response:
- mcause = 0x8000_000B
- mtval = 0
- o_redirect_pc = 0x0000_022C
REQ-042 Priority and masking cases:
- exception and interrupt in the same cycle -> mcause bit 31 = 0
- interrupt with MIE=0 -> no sequence starts
- interrupt with i_mret_e=1 -> no sequence starts
REQ-043 Mid-sequence behaviour:
- i_exc_valid_m pulsed during W_MCAUSE -> ignored; exactly 6 busy cycles
- i_rst asserted during W_MTVAL -> IDLE next cycle; no 0x300 write and no redirect
REQ-044 mstatus update: i_mstatus=0x0000_0008 -> W_MSTATUS writes 0x0000_1880.

Source files
------------

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: on an exception or external interrupt it flushes the pipe,
// writes mepc/mcause/mtval/mstatus one per cycle, then redirects the PC to the handler.
module trap_sequencer (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_exc_valid_m,
   input  logic [3:0]  i_exc_cause_m,
   input  logic [31:0] i_tval_m,
   input  logic [31:0] i_pc_m,
   input  logic        i_pc_valid_m,
   input  logic        i_irq_ext,
   input  logic [31:0] i_mstatus,
   input  logic        i_mie_meie,
   input  logic [31:0] i_mtvec,
   input  logic        i_mret_e,
   output logic        o_flush_all,
   output logic        o_pc_stall,
   output logic        o_redirect_valid,
   output logic [31:0] o_redirect_pc,
   output logic        o_csr_we,
   output logic [11:0] o_csr_addr,
   output logic [31:0] o_csr_wdata,
   output logic        o_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_W_MEPC,
      S_W_MCAUSE,
      S_W_MTVAL,
      S_W_MSTATUS,
      S_REDIRECT
   } state_t;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [3:0]  CAUSE_MEI   = 4'd11;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        irq_q, irq_d;
   logic [3:0]  cause_q, cause_d;
   logic [31:0] tval_q, tval_d;
   logic [31:0] mstatus_q, mstatus_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic        take_exc, take_irq;
   logic [31:0] vec_base;

   // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- machine.
   function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
      logic [31:0] r;
      r       = m;
      r[7]    = m[3];
      r[3]    = 1'b0;
      r[12:11] = 2'b11;
      return r;
   endfunction

   always_comb begin
      take_exc  = i_exc_valid_m;
      take_irq  = i_irq_ext & i_mie_meie & i_mstatus[3] & i_pc_valid_m & ~i_mret_e & ~i_exc_valid_m;
      state_d   = state_q;
      pc_d      = pc_q;
      irq_d     = irq_q;
      cause_d   = cause_q;
      tval_d    = tval_q;
      mstatus_d = mstatus_q;
      mtvec_d   = mtvec_q;
      case (state_q)
         S_IDLE: begin
            if (take_exc || take_irq) begin
               state_d   = S_FLUSH;
               pc_d      = i_pc_m;
               irq_d     = take_irq;
               cause_d   = take_exc ? i_exc_cause_m : CAUSE_MEI;
               tval_d    = take_exc ? i_tval_m : 32'd0;
               mstatus_d = i_mstatus;
               mtvec_d   = i_mtvec;
            end
         end
         S_FLUSH:     state_d = S_W_MEPC;
         S_W_MEPC:    state_d = S_W_MCAUSE;
         S_W_MCAUSE:  state_d = S_W_MTVAL;
         S_W_MTVAL:   state_d = S_W_MSTATUS;
         S_W_MSTATUS: state_d = S_REDIRECT;
         default:     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         irq_q     <= 1'b0;
         cause_q   <= '0;
         tval_q    <= '0;
         mstatus_q <= '0;
         mtvec_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         irq_q     <= irq_d;
         cause_q   <= cause_d;
         tval_q    <= tval_d;
         mstatus_q <= mstatus_d;
         mtvec_q   <= mtvec_d;
      end
   end

   // Vectored mode only applies to interrupts; exceptions always land on the base.
   assign vec_base = {mtvec_q[31:2], 2'b00};

   always_comb begin
      o_busy           = (state_q != S_IDLE);
      o_flush_all      = (state_q != S_IDLE);
      o_pc_stall       = 1'b0;
      o_redirect_valid = 1'b0;
      o_redirect_pc    = 32'd0;
      o_csr_we         = 1'b0;
      o_csr_addr       = 12'd0;
      o_csr_wdata      = 32'd0;
      case (state_q)
         S_FLUSH: o_pc_stall = 1'b1;
         S_W_MEPC: begin
            o_pc_stall  = 1'b1;
            o_csr_we    = 1'b1;
            o_csr_addr  = CSR_MEPC;
            o_csr_wdata = pc_q & 32'hFFFF_FFFC;
         end
         S_W_MCAUSE: begin
            o_pc_stall  = 1'b1;
            o_csr_we    = 1'b1;
            o_csr_addr  = CSR_MCAUSE;
            o_csr_wdata = {irq_q, 27'd0, cause_q};
         end
         S_W_MTVAL: begin
            o_pc_stall  = 1'b1;
            o_csr_we    = 1'b1;
            o_csr_addr  = CSR_MTVAL;
            o_csr_wdata = tval_q;
         end
         S_W_MSTATUS: begin
            o_pc_stall  = 1'b1;
            o_csr_we    = 1'b1;
            o_csr_addr  = CSR_MSTATUS;
            o_csr_wdata = trap_mstatus(mstatus_q);
         end
         S_REDIRECT: begin
            o_redirect_valid = 1'b1;
            if (irq_q && (mtvec_q[1:0] == 2'b01))
               o_redirect_pc = vec_base + {26'd0, cause_q, 2'b00};
            else
               o_redirect_pc = vec_base;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: exception, vectored interrupt, priority, masking,
// mid-sequence input pulses and mid-sequence reset, against hand-computed CSR/redirect values.
module tb_trap_sequencer;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_exc_valid_m;
   logic [3:0]  i_exc_cause_m;
   logic [31:0] i_tval_m;
   logic [31:0] i_pc_m;
   logic        i_pc_valid_m;
   logic        i_irq_ext;
   logic [31:0] i_mstatus;
   logic        i_mie_meie;
   logic [31:0] i_mtvec;
   logic        i_mret_e;
   logic        o_flush_all;
   logic        o_pc_stall;
   logic        o_redirect_valid;
   logic [31:0] o_redirect_pc;
   logic        o_csr_we;
   logic [11:0] o_csr_addr;
   logic [31:0] o_csr_wdata;
   logic        o_busy;

   int n_checks = 0;
   int n_fails  = 0;

   trap_sequencer dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_exc_valid_m    (i_exc_valid_m),
      .i_exc_cause_m    (i_exc_cause_m),
      .i_tval_m         (i_tval_m),
      .i_pc_m           (i_pc_m),
      .i_pc_valid_m     (i_pc_valid_m),
      .i_irq_ext        (i_irq_ext),
      .i_mstatus        (i_mstatus),
      .i_mie_meie       (i_mie_meie),
      .i_mtvec          (i_mtvec),
      .i_mret_e         (i_mret_e),
      .o_flush_all      (o_flush_all),
      .o_pc_stall       (o_pc_stall),
      .o_redirect_valid (o_redirect_valid),
      .o_redirect_pc    (o_redirect_pc),
      .o_csr_we         (o_csr_we),
      .o_csr_addr       (o_csr_addr),
      .o_csr_wdata      (o_csr_wdata),
      .o_busy           (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_exc_valid_m = 1'b0;
      i_exc_cause_m = 4'd0;
      i_tval_m      = 32'd0;
      i_pc_m        = 32'd0;
      i_pc_valid_m  = 1'b0;
      i_irq_ext     = 1'b0;
      i_mstatus     = 32'd0;
      i_mie_meie    = 1'b0;
      i_mtvec       = 32'd0;
      i_mret_e      = 1'b0;
   endtask

   // Flags packed as {busy, flush, stall, csr_we, redirect_valid}.
   task automatic check_idle(input string tag);
      check({tag, " flags"}, {27'd0, o_busy, o_flush_all, o_pc_stall, o_csr_we, o_redirect_valid}, 32'd0);
      check({tag, " addr"},  {20'd0, o_csr_addr}, 32'd0);
      check({tag, " wdata"}, o_csr_wdata, 32'd0);
      check({tag, " rpc"},   o_redirect_pc, 32'd0);
   endtask

   // Entered with FLUSH visible; checks ncyc cycles, stepping after each. pulse_cyc raises
   // i_exc_valid_m for one cycle after the checks of that cycle.
   task automatic run_seq(input string tag, input logic [31:0] mepc, input logic [31:0] mcause,
                          input logic [31:0] mtval, input logic [31:0] mst, input logic [31:0] rpc,
                          input int pulse_cyc, input int ncyc);
      logic [4:0]  ef;
      logic [11:0] ea;
      logic [31:0] ed;
      logic [31:0] ep;
      for (int c = 1; c <= ncyc; c++) begin
         ea = 12'd0; ed = 32'd0; ep = 32'd0;
         case (c)
            1: ef = 5'b11100;
            2: begin ef = 5'b11110; ea = 12'h341; ed = mepc;   end
            3: begin ef = 5'b11110; ea = 12'h342; ed = mcause; end
            4: begin ef = 5'b11110; ea = 12'h343; ed = mtval;  end
            5: begin ef = 5'b11110; ea = 12'h300; ed = mst;    end
            default: begin ef = 5'b11001; ep = rpc; end
         endcase
         check($sformatf("%s c%0d flags", tag, c),
               {27'd0, o_busy, o_flush_all, o_pc_stall, o_csr_we, o_redirect_valid}, {27'd0, ef});
         check($sformatf("%s c%0d addr", tag, c), {20'd0, o_csr_addr}, {20'd0, ea});
         check($sformatf("%s c%0d wdata", tag, c), o_csr_wdata, ed);
         check($sformatf("%s c%0d rpc", tag, c), o_redirect_pc, ep);
         i_exc_valid_m = (c == pulse_cyc);
         step();
      end
      i_exc_valid_m = 1'b0;
   endtask

   initial begin
      clear_inputs();
      // Reset wins over a pending exception.
      i_rst = 1'b1;
      i_exc_valid_m = 1'b1;
      i_pc_m = 32'h0000_0100;
      step();
      step();
      check_idle("reset");
      clear_inputs();
      i_rst = 1'b0;
      step();
      check_idle("post_reset");

      // Exception path; mstatus 0x8 -> 0x1880.
      i_exc_valid_m = 1'b1;
      i_exc_cause_m = 4'd2;
      i_pc_m        = 32'h0000_0104;
      i_pc_valid_m  = 1'b1;
      i_tval_m      = 32'hDEAD_BEEF;
      i_mtvec       = 32'h0000_0200;
      i_mstatus     = 32'h0000_0008;
      step();
      clear_inputs();
      run_seq("exc", 32'h0000_0104, 32'h0000_0002, 32'hDEAD_BEEF, 32'h0000_1880, 32'h0000_0200, 0, 6);
      check_idle("exc_end");

      // Vectored interrupt accepted in the IDLE cycle right after REDIRECT.
      i_irq_ext    = 1'b1;
      i_mie_meie   = 1'b1;
      i_mstatus    = 32'h0000_000C;
      i_pc_valid_m = 1'b1;
      i_pc_m       = 32'h0000_0400;
      i_tval_m     = 32'h0000_1234;
      i_mtvec      = 32'h0000_0201;
      step();
      clear_inputs();
      run_seq("irq", 32'h0000_0400, 32'h8000_000B, 32'h0000_0000, 32'h0000_1884, 32'h0000_022C, 0, 6);
      check_idle("irq_end");

      // Exception and interrupt together: exception wins, vectored mode not applied.
      i_exc_valid_m = 1'b1;
      i_exc_cause_m = 4'd5;
      i_tval_m      = 32'h0BAD_F00D;
      i_pc_m        = 32'h0000_020B;
      i_pc_valid_m  = 1'b1;
      i_irq_ext     = 1'b1;
      i_mie_meie    = 1'b1;
      i_mstatus     = 32'h0000_0008;
      i_mtvec       = 32'h0000_0301;
      step();
      clear_inputs();
      run_seq("prio", 32'h0000_0208, 32'h0000_0005, 32'h0BAD_F00D, 32'h0000_1880, 32'h0000_0300, 0, 6);
      check_idle("prio_end");

      // Interrupt masked by MIE=0.
      i_irq_ext    = 1'b1;
      i_mie_meie   = 1'b1;
      i_mstatus    = 32'h0000_0000;
      i_pc_valid_m = 1'b1;
      i_mtvec      = 32'h0000_0200;
      step();
      check_idle("mask_mie");
      // Interrupt held off by mret in EX.
      i_mstatus = 32'h0000_0008;
      i_mret_e  = 1'b1;
      step();
      check_idle("mask_mret");
      // Interrupt held off by a bubble in MEM.
      i_mret_e     = 1'b0;
      i_pc_valid_m = 1'b0;
      step();
      check_idle("mask_bubble");
      // Exception still taken alongside mret.
      i_irq_ext     = 1'b0;
      i_mret_e      = 1'b1;
      i_exc_valid_m = 1'b1;
      i_exc_cause_m = 4'd3;
      i_pc_m        = 32'h0000_0010;
      i_tval_m      = 32'h0000_0010;
      i_mstatus     = 32'h0000_0000;
      i_mtvec       = 32'h0000_0400;
      step();
      clear_inputs();
      // Pulse during W_MCAUSE must be ignored and not queued.
      run_seq("mret_exc", 32'h0000_0010, 32'h0000_0003, 32'h0000_0010, 32'h0000_1800, 32'h0000_0400, 3, 6);
      check_idle("pulse_end");
      step();
      check_idle("pulse_not_queued");

      // Reset in W_MTVAL abandons the sequence.
      i_exc_valid_m = 1'b1;
      i_exc_cause_m = 4'd7;
      i_pc_m        = 32'h0000_0500;
      i_tval_m      = 32'h1111_2222;
      i_mstatus     = 32'h0000_0008;
      i_mtvec       = 32'h0000_0600;
      step();
      clear_inputs();
      run_seq("rst_mid", 32'h0000_0500, 32'h0000_0007, 32'h1111_2222, 32'h0000_1880, 32'h0000_0600, 0, 3);
      check("rst_mid c4 addr", {20'd0, o_csr_addr}, 32'h0000_0343);
      i_rst = 1'b1;
      step();
      check_idle("rst_mid_after");
      i_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check_idle($sformatf("rst_mid_quiet%0d", k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
